// File: rtl/bru_pkg.sv
// Shared constants and helpers for the branch redirect unit: table geometry defaults,
// 2-bit predictor counter states and saturating counter arithmetic.
package bru_pkg;

   localparam int unsigned IDX_W_DEFAULT = 6;
   localparam int unsigned CNT_W_DEFAULT = 32;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   function automatic logic [1:0] sat_inc(input logic [1:0] cnt);
      return (cnt == ST) ? ST : cnt + 2'd1;
   endfunction

   function automatic logic [1:0] sat_dec(input logic [1:0] cnt);
      return (cnt == SNT) ? SNT : cnt - 2'd1;
   endfunction

endpackage

// File: rtl/bru_btb.sv
// Direct-mapped branch target buffer: asynchronous lookup, synchronous write.
// Instantiated by branch_redirect_unit only when BRU_BTB_EN is defined.
module bru_btb
   import bru_pkg::*;
#(
   parameter int unsigned IDX_W = IDX_W_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] rd_pc_i,
   output logic        hit_o,
   output logic [31:0] rd_target_o,
   input  logic        wr_en_i,
   input  logic [31:0] wr_pc_i,
   input  logic [31:0] wr_target_i
);

   localparam int unsigned N     = 1 << IDX_W;
   localparam int unsigned TAG_W = 30 - IDX_W;

   logic             valid_q  [N];
   logic [TAG_W-1:0] tag_q    [N];
   logic [31:0]      target_q [N];

   logic [IDX_W-1:0] rd_idx, wr_idx;
   logic             unused_pc_lsbs;

   assign rd_idx         = rd_pc_i[IDX_W+1:2];
   assign wr_idx         = wr_pc_i[IDX_W+1:2];
   assign unused_pc_lsbs = ^{rd_pc_i[1:0], wr_pc_i[1:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) valid_q[i] <= 1'b0;
      end else if (wr_en_i) begin
         valid_q[wr_idx] <= 1'b1;
      end
   end

   // Tag and target are qualified by the valid bit, so they carry no reset.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         tag_q[wr_idx]    <= wr_pc_i[31:IDX_W+2];
         target_q[wr_idx] <= wr_target_i;
      end
   end

   assign hit_o       = valid_q[rd_idx] & (tag_q[rd_idx] == rd_pc_i[31:IDX_W+2]);
   assign rd_target_o = target_q[rd_idx];

endmodule

// File: rtl/branch_redirect_unit.sv
// Fetch-side branch prediction (BHT, plus BTB when BRU_BTB_EN is defined) and execute-side
// resolution that drives the fetch redirect, pipeline flushes and branch statistics.
module branch_redirect_unit
   import bru_pkg::*;
#(
   parameter int unsigned IDX_W = IDX_W_DEFAULT,
   parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      pc_f,
   output logic             pred_taken_f,
   output logic [31:0]      pred_target_f,
   input  logic             valid_e,
   input  logic             branch_e,
   input  logic             jump_e,
   input  logic             taken_e,
   input  logic [31:0]      pc_e,
   input  logic [31:0]      pc_plus4_e,
   input  logic [31:0]      target_e,
   input  logic             pred_taken_e,
   input  logic [31:0]      pred_target_e,
   output logic             pc_src_e,
   output logic [31:0]      pc_target_e,
   output logic             flush_d,
   output logic             flush_e,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispred_cnt
);

   localparam int unsigned N = 1 << IDX_W;

   logic             actual, mispred, train;
   logic [31:0]      act_tgt;
   logic [IDX_W-1:0] idx_e;
   logic [1:0]       bht_q [N];
   logic [1:0]       bht_d;
   logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
   logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;
   logic             pred_taken_raw;
   logic [31:0]      pred_target_raw;

   assign idx_e = pc_e[IDX_W+1:2];

   // NOTE: always_comb assigns every variable on every path, so no latch is inferred.
   always_comb begin
      actual  = jump_e | (branch_e & taken_e);
      act_tgt = actual ? target_e : pc_plus4_e;
      mispred = valid_e & ((actual != pred_taken_e) | (actual & (pred_target_e != target_e)));
      train   = valid_e & (branch_e | jump_e);

      if (jump_e)      bht_d = ST;
      else if (actual) bht_d = sat_inc(bht_q[idx_e]);
      else             bht_d = sat_dec(bht_q[idx_e]);

      branch_cnt_d  = branch_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
      if (train && !(&branch_cnt_q))    branch_cnt_d  = branch_cnt_q + CNT_W'(1);
      if (mispred && !(&mispred_cnt_q)) mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
   end

   // NOTE: the BHT is reset explicitly because a reset must restore every entry to WNT at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) bht_q[i] <= WNT;
      end else if (train) begin
         bht_q[idx_e] <= bht_d;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

`ifdef BRU_BTB_EN
   logic             btb_hit;
   logic [31:0]      btb_target;
   logic [IDX_W-1:0] idx_f;

   assign idx_f = pc_f[IDX_W+1:2];

   bru_btb #(
      .IDX_W(IDX_W)
   ) u_btb (
      .clk        (clk),
      .rst        (rst),
      .rd_pc_i    (pc_f),
      .hit_o      (btb_hit),
      .rd_target_o(btb_target),
      .wr_en_i    (train & actual),
      .wr_pc_i    (pc_e),
      .wr_target_i(target_e)
   );

   // Lookup reads the registered table, so a same-cycle update is seen one cycle later.
   assign pred_taken_raw  = btb_hit & bht_q[idx_f][1];
   assign pred_target_raw = pred_taken_raw ? btb_target : pc_f + 32'd4;
`else
   logic unused_pc_e;

   assign unused_pc_e     = ^{pc_e[31:IDX_W+2], pc_e[1:0]};
   assign pred_taken_raw  = 1'b0;
   assign pred_target_raw = pc_f + 32'd4;
`endif

   assign pred_taken_f  = pred_taken_raw & ~rst;
   assign pred_target_f = rst ? 32'd0 : pred_target_raw;
   assign pc_src_e      = mispred & ~rst;
   assign flush_d       = mispred & ~rst;
   assign flush_e       = mispred & ~rst;
   assign pc_target_e   = rst ? 32'd0 : act_tgt;
   assign branch_cnt    = branch_cnt_q;
   assign mispred_cnt   = mispred_cnt_q;

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Self-checking bench for branch_redirect_unit: table-driven resolution vectors plus
// directed reset, predictor-training and counter-saturation sequences.
module tb_branch_redirect_unit;

   localparam int unsigned IDX_W = 6;
   localparam int unsigned CNT_W = 4;
   localparam int          CMAX  = 15;

   logic             clk = 1'b0;
   logic             rst;
   logic [31:0]      pc_f;
   logic             pred_taken_f;
   logic [31:0]      pred_target_f;
   logic             valid_e, branch_e, jump_e, taken_e, pred_taken_e;
   logic [31:0]      pc_e, pc_plus4_e, target_e, pred_target_e;
   logic             pc_src_e, flush_d, flush_e;
   logic [31:0]      pc_target_e;
   logic [CNT_W-1:0] branch_cnt, mispred_cnt;

   int n_pass  = 0;
   int n_total = 0;
   int exp_br  = 0;
   int exp_mp  = 0;

   typedef struct {
      logic        valid;
      logic        branch;
      logic        jump;
      logic        taken;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] tgt;
      logic        ptk;
      logic [31:0] ptgt;
      logic        exp_src;
      logic [31:0] exp_tgt;
   } vec_t;

   vec_t vecs [11];

   branch_redirect_unit #(
      .IDX_W(IDX_W),
      .CNT_W(CNT_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .pc_f         (pc_f),
      .pred_taken_f (pred_taken_f),
      .pred_target_f(pred_target_f),
      .valid_e      (valid_e),
      .branch_e     (branch_e),
      .jump_e       (jump_e),
      .taken_e      (taken_e),
      .pc_e         (pc_e),
      .pc_plus4_e   (pc_plus4_e),
      .target_e     (target_e),
      .pred_taken_e (pred_taken_e),
      .pred_target_e(pred_target_e),
      .pc_src_e     (pc_src_e),
      .pc_target_e  (pc_target_e),
      .flush_d      (flush_d),
      .flush_e      (flush_e),
      .branch_cnt   (branch_cnt),
      .mispred_cnt  (mispred_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic drive_e(input logic v, input logic br, input logic jp, input logic tk,
                          input logic [31:0] pc, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptgt);
      valid_e       = v;
      branch_e      = br;
      jump_e        = jp;
      taken_e       = tk;
      pc_e          = pc;
      pc_plus4_e    = pc + 32'd4;
      target_e      = tgt;
      pred_taken_e  = ptk;
      pred_target_e = ptgt;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected-counter model: one resolved instruction per clock edge, saturating.
   task automatic model_count(input logic trained, input logic mis);
      if (trained && exp_br != CMAX) exp_br++;
      if (mis && exp_mp != CMAX) exp_mp++;
   endtask

   task automatic check_redirect(input string tag, input logic src, input logic [31:0] tgt);
      check({tag, " pc_src_e"},    32'(pc_src_e), 32'(src));
      check({tag, " flush_d"},     32'(flush_d),  32'(src));
      check({tag, " flush_e"},     32'(flush_e),  32'(src));
      check({tag, " pc_target_e"}, pc_target_e,   tgt);
   endtask

   task automatic check_counts(input string tag);
      check({tag, " branch_cnt"},  32'(branch_cnt),  32'(exp_br));
      check({tag, " mispred_cnt"}, 32'(mispred_cnt), 32'(exp_mp));
   endtask

   initial begin
      //          v  br jp tk pc      pc4     tgt     ptk ptgt    src tgt
      vecs[0]  = '{1, 1, 0, 1, 32'h40, 32'h44, 32'h20, 0, 32'h44, 1, 32'h20};
      vecs[1]  = '{1, 1, 0, 1, 32'h40, 32'h44, 32'h20, 1, 32'h20, 0, 32'h20};
      vecs[2]  = '{1, 1, 0, 1, 32'h40, 32'h44, 32'h20, 1, 32'h24, 1, 32'h20};
      vecs[3]  = '{1, 1, 0, 0, 32'h40, 32'h44, 32'h20, 1, 32'h20, 1, 32'h44};
      vecs[4]  = '{1, 1, 0, 0, 32'h40, 32'h44, 32'h20, 0, 32'h44, 0, 32'h44};
      vecs[5]  = '{0, 1, 0, 1, 32'h40, 32'h44, 32'h20, 0, 32'h44, 0, 32'h20};
      vecs[6]  = '{1, 0, 0, 1, 32'h100, 32'h104, 32'h180, 1, 32'h180, 1, 32'h104};
      vecs[7]  = '{1, 0, 1, 0, 32'h80, 32'h84, 32'h200, 0, 32'h84, 1, 32'h200};
      vecs[8]  = '{1, 0, 1, 0, 32'h80, 32'h84, 32'h200, 1, 32'h200, 0, 32'h200};
      vecs[9]  = '{1, 0, 0, 0, 32'h100, 32'h104, 32'h180, 0, 32'h104, 0, 32'h104};
      vecs[10] = '{1, 1, 0, 0, 32'h40, 32'h44, 32'h20, 0, 32'h999, 0, 32'h44};

      // Power-on reset with a mispredicting instruction present: all outputs held low.
      rst  = 1'b1;
      pc_f = 32'h40;
      drive_e(1, 1, 0, 1, 32'h40, 32'h20, 0, 32'h44);
      #2;
      check_redirect("por", 1'b0, 32'h0);
      check_counts("por");
      tick();
      rst = 1'b0;
      drive_e(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h4);
      pc_f = 32'h1234;
      #1;
      check("por pred_taken_f",  32'(pred_taken_f), 32'h0);
      check("por pred_target_f", pred_target_f,     32'h1238);

      // Table-driven resolution vectors, one per cycle.
      tick();
      for (int i = 0; i < 11; i++) begin
         drive_e(vecs[i].valid, vecs[i].branch, vecs[i].jump, vecs[i].taken,
                 vecs[i].pc, vecs[i].tgt, vecs[i].ptk, vecs[i].ptgt);
         check("vec pc_plus4 sanity", pc_plus4_e, vecs[i].pc4);
         #1;
         check_redirect($sformatf("vec%0d", i), vecs[i].exp_src, vecs[i].exp_tgt);
         tick();
         model_count(vecs[i].valid & (vecs[i].branch | vecs[i].jump), vecs[i].exp_src);
         check_counts($sformatf("vec%0d", i));
      end

      // Reset asserted mid-run: redirect drops and counters clear without a clock edge.
      drive_e(1, 0, 1, 0, 32'h80, 32'h200, 0, 32'h84);
      #1;
      check("pre-reset pc_src_e", 32'(pc_src_e), 32'h1);
      rst = 1'b1;
      #1;
      exp_br = 0;
      exp_mp = 0;
      check_redirect("midrst", 1'b0, 32'h0);
      check_counts("midrst");
      drive_e(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h4);
      #2;
      rst = 1'b0;
      tick();
      pc_f = 32'h40;
      #1;
      check("midrst pred_taken_f",  32'(pred_taken_f), 32'h0);
      check("midrst pred_target_f", pred_target_f,     32'h44);

`ifdef BRU_BTB_EN
      // Loop branch at 0x40 -> 0x20, taken four times.
      for (int k = 0; k < 4; k++) begin
         pc_f = 32'h40;
         #1;
         check($sformatf("loop%0d pred_taken_f", k), 32'(pred_taken_f), (k == 0) ? 32'h0 : 32'h1);
         check($sformatf("loop%0d pred_target_f", k), pred_target_f, (k == 0) ? 32'h44 : 32'h20);
         drive_e(1, 1, 0, 1, 32'h40, 32'h20, (k != 0), (k == 0) ? 32'h44 : 32'h20);
         #1;
         check_redirect($sformatf("loop%0d", k), (k == 0), 32'h20);
         tick();
         model_count(1'b1, (k == 0));
      end
      check_counts("loop");

      // Loop exit: ST -> WT still predicts taken, WT -> WNT then predicts not taken.
      for (int k = 0; k < 2; k++) begin
         drive_e(1, 1, 0, 0, 32'h40, 32'h20, 1, 32'h20);
         #1;
         check_redirect($sformatf("exit%0d", k), 1'b1, 32'h44);
         tick();
         model_count(1'b1, 1'b1);
         pc_f = 32'h40;
         #1;
         check($sformatf("exit%0d pred_taken_f", k), 32'(pred_taken_f), (k == 0) ? 32'h1 : 32'h0);
      end
      check_counts("exit");

      // Alias at 0x100: redirect to fall-through, nothing trained.
      pc_f = 32'h100;
      drive_e(1, 0, 0, 1, 32'h100, 32'h180, 1, 32'h180);
      #1;
      check_redirect("alias", 1'b1, 32'h104);
      tick();
      model_count(1'b0, 1'b1);
      drive_e(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h4);
      #1;
      check("alias pred_taken_f", 32'(pred_taken_f), 32'h0);
      check_counts("alias");

      // Same-cycle lookup and update at index 5 (pc 0x14): old value until the edge.
      pc_f = 32'h14;
      drive_e(1, 1, 0, 1, 32'h14, 32'h300, 0, 32'h18);
      #1;
      check("idx5 before taken", 32'(pred_taken_f), 32'h0);
      tick();
      check("idx5 after taken",  32'(pred_taken_f), 32'h1);
      check("idx5 btb target",   pred_target_f,     32'h300);
      drive_e(1, 1, 0, 0, 32'h14, 32'h300, 1, 32'h300);
      #1;
      check("idx5 before not-taken", 32'(pred_taken_f), 32'h1);
      tick();
      check("idx5 after not-taken",  32'(pred_taken_f), 32'h0);
`else
      // Static not-taken: JAL to 0x200 mispredicts every time; mispred_cnt saturates.
      for (int k = 0; k < 20; k++) begin
         pc_f = 32'h80;
         drive_e(1, 0, 1, 0, 32'h80, 32'h200, 0, 32'h84);
         #1;
         check($sformatf("jal%0d pred_taken_f", k),  32'(pred_taken_f), 32'h0);
         check($sformatf("jal%0d pred_target_f", k), pred_target_f,     32'h84);
         check($sformatf("jal%0d pc_src_e", k),      32'(pc_src_e),     32'h1);
         check($sformatf("jal%0d pc_target_e", k),   pc_target_e,       32'h200);
         tick();
         model_count(1'b1, 1'b1);
         check_counts($sformatf("jal%0d", k));
      end
      check("jal saturated mispred_cnt", 32'(mispred_cnt), 32'd15);
`endif

      drive_e(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h4);
      tick();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
